// File: rtl/mem_access_unit_if.sv
// CPU request/response channel and data-memory port of the memory access unit.
`timescale 1ns/1ps
interface mem_access_unit_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sign;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // Unit side: takes CPU requests and memory read data, drives results and the memory port.
  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_done, cpu_err, busy, mem_addr, mem_wdata, mem_write
  );

  // Environment side: CPU plus data memory.
  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_done, cpu_err, busy, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a word-wide data memory.
// Partial stores are done as read-modify-write of the containing word.
//
// state | meaning
// IDLE  | waiting for cpu_req; request fields are latched on accept
// RD    | mem_addr presented; load result or merged store word is captured
// WR    | one-cycle mem_write of the final word
// DONE  | cpu_done pulse with cpu_err for the finished transaction
`timescale 1ns/1ps
module mem_access_unit (
  input logic         clk,
  input logic         reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q;
  logic        we_q, sign_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] cpu_rdata_q, mem_addr_q, mem_wdata_q;
  logic        cpu_done_q, cpu_err_q, busy_q, mem_write_q;

  logic        req_err_d;
  logic [7:0]  lane_byte_d;
  logic [15:0] lane_half_d;
  logic [31:0] load_d, merge_d;

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_write = mem_write_q;

  // Reserved size or a half/word address that is not naturally aligned.
  always_comb begin
    req_err_d = 1'b0;
    case (bus.cpu_size)
      2'b00:   req_err_d = 1'b0;
      2'b01:   req_err_d = bus.cpu_addr[0];
      2'b10:   req_err_d = |bus.cpu_addr[1:0];
      default: req_err_d = 1'b1;
    endcase
  end

  // Little-endian lane select and sign/zero extension of the load result.
  always_comb begin
    lane_byte_d = bus.mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00: lane_byte_d = bus.mem_rdata[7:0];
      2'b01: lane_byte_d = bus.mem_rdata[15:8];
      2'b10: lane_byte_d = bus.mem_rdata[23:16];
      2'b11: lane_byte_d = bus.mem_rdata[31:24];
    endcase
    lane_half_d = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_d = {{24{sign_q & lane_byte_d[7]}}, lane_byte_d};
      2'b01:   load_d = {{16{sign_q & lane_half_d[15]}}, lane_half_d};
      default: load_d = bus.mem_rdata;
    endcase
  end

  // Read word with the addressed byte/half lane overwritten by the store data.
  always_comb begin
    merge_d = bus.mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'b00: merge_d[7:0]   = wdata_q[7:0];
        2'b01: merge_d[15:8]  = wdata_q[7:0];
        2'b10: merge_d[23:16] = wdata_q[7:0];
        2'b11: merge_d[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_d[31:16] = wdata_q[15:0];
    end else begin
      merge_d[15:0] = wdata_q[15:0];
    end
  end

  // Transaction FSM; every output is registered for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cpu_rdata_q <= 32'h0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_write_q <= 1'b0;
    end else begin
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_addr_q  <= 32'h0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            size_q  <= bus.cpu_size;
            sign_q  <= bus.cpu_sign;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            busy_q  <= 1'b1;
            if (req_err_d) begin
              state_q    <= DONE;
              cpu_done_q <= 1'b1;
              cpu_err_q  <= 1'b1;
            end else if (bus.cpu_we && bus.cpu_size == 2'b10) begin
              state_q     <= WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.cpu_wdata;
              mem_addr_q  <= {bus.cpu_addr[31:2], 2'b00};
            end else begin
              state_q    <= RD;
              mem_addr_q <= {bus.cpu_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merge_d;
            mem_addr_q  <= {addr_q[31:2], 2'b00};
          end else begin
            state_q     <= DONE;
            cpu_rdata_q <= load_d;
            cpu_done_q  <= 1'b1;
          end
        end
        WR: begin
          state_q    <= DONE;
          cpu_done_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
